// File: rtl/e_mdu.sv
// Iterative multiply/divide unit with a pass-through tag; MDU_SINGLE_CYCLE_MUL_EN selects a combinational multiplier for ops 0-2.
// Latency: DATA_W+2 cycles from accept edge to valid_o for iterative ops, 1 cycle for the fast multiply.
// Backpressure: one op in flight; ready_o only in IDLE; result held in DONE until valid_o & ready_i; flush_i kills everything.
module e_mdu #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] r1_i,
  input  logic [DATA_W-1:0] r0_i,
  input  logic [ID_W-1:0]   id_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic [ID_W-1:0]   id_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [ID_W-1:0]   id_q;
  logic              neg_q;    // quotient/product sign
  logic              rneg_q;   // dividend sign, applied to the remainder
  logic              div0_q;
  logic [DATA_W-1:0] r1_q;     // raw dividend, returned as remainder on divide by zero
  logic [DATA_W-1:0] hi_q;     // partial remainder / product high half
  logic [DATA_W-1:0] lo_q;     // quotient / product low half (multiplier shifts out)
  logic [DATA_W-1:0] dvs_q;    // divisor / multiplicand magnitude

  logic              accept;
  logic              in_signed, a_neg, b_neg, in_mul;
  logic [DATA_W-1:0] a_mag, b_mag;

  assign ready_o = (state == IDLE);
  assign accept  = valid_i & ready_o & ~flush_i;

  // Operand magnitudes and signs at the request boundary
  always_comb begin
    in_signed = (op_i == 3'd1) || (op_i == 3'd3) || (op_i == 3'd4);
    in_mul    = (op_i < 3'd3);
    a_neg     = in_signed & r1_i[DATA_W-1];
    b_neg     = in_signed & r0_i[DATA_W-1];
    a_mag     = a_neg ? (-r1_i) : r1_i;
    b_mag     = b_neg ? (-r0_i) : r0_i;
  end

  logic [DATA_W:0]   shifted, trial, sum;
  logic [DATA_W-1:0] hi_n, lo_n;

  // One radix-2 step: restoring divide or shift-add multiply
  always_comb begin
    shifted = {hi_q, lo_q[DATA_W-1]};
    trial   = shifted - {1'b0, dvs_q};
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    if (op_q < 3'd3) begin
      hi_n = sum[DATA_W:1];
      lo_n = {sum[0], lo_q[DATA_W-1:1]};
    end else if (!trial[DATA_W]) begin
      hi_n = trial[DATA_W-1:0];
      lo_n = {lo_q[DATA_W-2:0], 1'b1};
    end else begin
      hi_n = shifted[DATA_W-1:0];
      lo_n = {lo_q[DATA_W-2:0], 1'b0};
    end
  end

  logic [2*DATA_W-1:0] prod, prod_s;
  logic [DATA_W-1:0]   quo_s, rem_s, fix_res;

  // Sign fix-up and result selection at the end of iteration
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? (-prod) : prod;
    quo_s  = div0_q ? '1   : (neg_q  ? (-lo_q) : lo_q);
    rem_s  = div0_q ? r1_q : (rneg_q ? (-hi_q) : hi_q);
    case (op_q)
      3'd0:       fix_res = prod_s[DATA_W-1:0];
      3'd1, 3'd2: fix_res = prod_s[2*DATA_W-1:DATA_W];
      3'd3, 3'd5: fix_res = quo_s;
      3'd4, 3'd6: fix_res = rem_s;
      default:    fix_res = '0;
    endcase
  end

`ifdef MDU_SINGLE_CYCLE_MUL_EN
  logic [2*DATA_W-1:0] fa_x, fb_x, fprod;
  logic [DATA_W-1:0]   fast_res;

  // Combinational multiplier on sign-extended operands; the low 2*DATA_W bits are exact
  always_comb begin
    fa_x  = {{DATA_W{in_signed & r1_i[DATA_W-1]}}, r1_i};
    fb_x  = {{DATA_W{in_signed & r0_i[DATA_W-1]}}, r0_i};
    fprod = fa_x * fb_x;
    fast_res = (op_i == 3'd0) ? fprod[DATA_W-1:0] : fprod[2*DATA_W-1:DATA_W];
  end
`endif

  // Control FSM and datapath registers; flush overrides every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      id_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      r1_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
      id_o     <= '0;
    end else if (flush_i) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= op_i;
            id_q   <= id_i;
            r1_q   <= r1_i;
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            div0_q <= (r0_i == '0);
            hi_q   <= '0;
            lo_q   <= in_mul ? b_mag : a_mag;
            dvs_q  <= in_mul ? a_mag : b_mag;
            cnt    <= '0;
`ifdef MDU_SINGLE_CYCLE_MUL_EN
            if (in_mul) begin
              state    <= DONE;
              valid_o  <= 1'b1;
              result_o <= fast_res;
              id_o     <= id_i;
            end else begin
              state <= CALC;
            end
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          result_o <= fix_res;
          id_o     <= id_q;
          valid_o  <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu at DATA_W=32: results, latency, hold, flush and reset.
// Latency counts cycles after the accept edge until valid_o is seen.
// Outputs are sampled on the falling edge; inputs change #1 after the rising edge.
module tb_e_mdu;

  localparam int DW  = 32;
  localparam int IW  = 6;
  localparam int LAT = DW + 2;
`ifdef MDU_SINGLE_CYCLE_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [2:0]    op_i = '0;
  logic [DW-1:0] r1_i = '0;
  logic [DW-1:0] r0_i = '0;
  logic [IW-1:0] id_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [DW-1:0] result_o;
  logic [IW-1:0] id_o;

  int errors = 0;
  int checks = 0;

  e_mdu #(.DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .r1_i(r1_i), .r0_i(r0_i), .id_i(id_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .id_o(id_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request in an IDLE cycle; returns #1 after the accept edge
  task automatic issue(input string tag, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [IW-1:0] id);
    @(negedge clk);
    chk({tag, " ready"}, ready_o, 1);
    valid_i = 1'b1; op_i = op; r1_i = a; r0_i = b; id_i = id;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    op_i = 3'($urandom); r1_i = $urandom; r0_i = $urandom; id_i = IW'($urandom);
  endtask

  // Wait (bounded) for valid_o and check latency, result and tag
  task automatic wait_result(input string tag, input logic [DW-1:0] exp,
                             input logic [IW-1:0] id, input int exp_lat);
    int n;
    n = 1;
    @(negedge clk);
    if (exp_lat > 1) begin
      chk({tag, " busy ready_o"}, ready_o, 0);
      chk({tag, " busy valid_o"}, valid_o, 0);
    end
    while (!valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " result"}, result_o, exp);
    chk({tag, " id"}, id_o, id);
  endtask

  // Consume the result and confirm return to IDLE with result held
  task automatic consume(input string tag, input logic [DW-1:0] exp);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    @(negedge clk);
    chk({tag, " post valid_o"}, valid_o, 0);
    chk({tag, " post ready_o"}, ready_o, 1);
    chk({tag, " post result held"}, result_o, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [IW-1:0] id,
                        input logic [DW-1:0] exp, input int exp_lat);
    issue(tag, op, a, b, id);
    wait_result(tag, exp, id, exp_lat);
    consume(tag, exp);
  endtask

  task automatic no_valid_window(input string tag);
    int vcnt;
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) vcnt++;
    end
    chk({tag, " stray valid_o"}, vcnt, 0);
  endtask

  initial begin
    // Reset values, before any clock edge
    #1;
    chk("reset ready_o", ready_o, 1);
    chk("reset valid_o", valid_o, 0);
    chk("reset result_o", result_o, 0);
    chk("reset id_o", id_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Division, signs, divide by zero, overflow
    run_op("div -7/2",   3'd3, 32'hFFFF_FFF9, 32'd2, 6'd5, 32'hFFFF_FFFD, LAT);
    run_op("mod -7/2",   3'd4, 32'hFFFF_FFF9, 32'd2, 6'd6, 32'hFFFF_FFFF, LAT);
    run_op("divu 7/0",   3'd5, 32'd7, 32'd0, 6'd7, 32'hFFFF_FFFF, LAT);
    run_op("modu 7/0",   3'd6, 32'd7, 32'd0, 6'd8, 32'd7, LAT);
    run_op("div -7/0",   3'd3, 32'hFFFF_FFF9, 32'd0, 6'd9, 32'hFFFF_FFFF, LAT);
    run_op("mod -7/0",   3'd4, 32'hFFFF_FFF9, 32'd0, 6'd10, 32'hFFFF_FFF9, LAT);
    run_op("div ovf",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11, 32'h8000_0000, LAT);
    run_op("mod ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 32'd0, LAT);
    run_op("div 100/-7", 3'd3, 32'd100, 32'hFFFF_FFF9, 6'd13, 32'hFFFF_FFF2, LAT);
    run_op("mod 100/-7", 3'd4, 32'd100, 32'hFFFF_FFF9, 6'd14, 32'd2, LAT);
    run_op("divu big",   3'd5, 32'hFFFF_FFF9, 32'd2, 6'd15, 32'h7FFF_FFFC, LAT);

    // Multiply variants
    run_op("mulh -1*2",  3'd1, 32'hFFFF_FFFF, 32'd2, 6'd16, 32'hFFFF_FFFF, MLAT);
    run_op("mulhu ff*2", 3'd2, 32'hFFFF_FFFF, 32'd2, 6'd17, 32'd1, MLAT);
    run_op("mul ff*2",   3'd0, 32'hFFFF_FFFF, 32'd2, 6'd18, 32'hFFFF_FFFE, MLAT);
    run_op("mulhu ff*ff",3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd19, 32'hFFFF_FFFE, MLAT);
    run_op("mul ff*ff",  3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd20, 32'd1, MLAT);
    run_op("mulh -3*5",  3'd1, 32'hFFFF_FFFD, 32'd5, 6'd21, 32'hFFFF_FFFF, MLAT);
    run_op("mulh min2",  3'd1, 32'h8000_0000, 32'h8000_0000, 6'd22, 32'h4000_0000, MLAT);

    // Reserved op
    run_op("op7",        3'd7, 32'd123, 32'd4, 6'd23, 32'd0, LAT);

    // Result held under backpressure; request during DONE handshake is not taken
    issue("hold", 3'd5, 32'd100, 32'd7, 6'd9);
    wait_result("hold", 32'd14, 6'd9, LAT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold valid_o", valid_o, 1);
      chk("hold result_o", result_o, 32'd14);
      chk("hold id_o", id_o, 6'd9);
      chk("hold ready_o", ready_o, 0);
    end
    ready_i = 1'b1;
    valid_i = 1'b1; op_i = 3'd5; r1_i = 32'd50; r0_i = 32'd5; id_i = 6'd30;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    @(negedge clk);
    chk("done no-accept ready_o", ready_o, 1);
    chk("done no-accept valid_o", valid_o, 0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    wait_result("after done", 32'd10, 6'd30, LAT);
    consume("after done", 32'd10);

    // Flush in IDLE drops the request of that cycle
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b1; op_i = 3'd5; r1_i = 32'd9; r0_i = 32'd3; id_i = 6'd1;
    @(posedge clk);
    #1;
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("idle flush ready_o", ready_o, 1);

    // Flush at CALC cycle 10
    issue("flush", 3'd3, 32'd1000, 32'd3, 6'd2);
    repeat (10) @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("flush ready_o", ready_o, 1);
    chk("flush valid_o", valid_o, 0);
    no_valid_window("flush");
    run_op("divu after flush", 3'd5, 32'd100, 32'd7, 6'd3, 32'd14, LAT);

    // Reset mid-CALC
    issue("rst", 3'd3, 32'd1000, 32'd3, 6'd4);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst ready_o", ready_o, 1);
    chk("midrst valid_o", valid_o, 0);
    chk("midrst result_o", result_o, 0);
    chk("midrst id_o", id_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    no_valid_window("midrst");
    run_op("divu after rst", 3'd5, 32'd100, 32'd7, 6'd5, 32'd14, LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
